// File: rtl/racer_pkg.sv
// Shared encodings for the multi-player race input block: screen codes,
// button-channel FSM states and small width helpers.
package racer_pkg;

   localparam logic [1:0] SCREEN_LOBBY  = 2'b00;
   localparam logic [1:0] SCREEN_RACE   = 2'b01;
   localparam logic [1:0] SCREEN_FINISH = 2'b10;

   localparam int SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      CH_LOCKED      = 3'd0,
      CH_IDLE        = 3'd1,
      CH_DEB_PRESS   = 3'd2,
      CH_HELD        = 3'd3,
      CH_DEB_RELEASE = 3'd4
   } ch_state_e;

   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/player_btn_channel.sv
// One button channel: 2-flop synchroniser, debounce counter and press/release
// FSM producing a single-cycle press pulse per accepted press.
module player_btn_channel
   import racer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press,
   output logic activity
);

   localparam int            CW       = clog2_min1(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] vld_pipe;
   logic                   s;
   logic                   s_vld;
   ch_state_e              state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;

   // vld_pipe marks when the synchroniser holds a real sample rather than its
   // reset value, so a button held through reset keeps the channel LOCKED.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q   <= '0;
         vld_pipe <= '0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], btn};
         vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign s        = sync_q[SYNC_STAGES-1];
   assign s_vld    = vld_pipe[SYNC_STAGES-1];
   assign activity = s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CH_LOCKED;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press   = 1'b0;
      case (state_q)
         CH_LOCKED: if (s_vld && !s) state_d = CH_IDLE;
         CH_IDLE: begin
            if (s) begin
               state_d = CH_DEB_PRESS;
               cnt_d   = '0;
            end
         end
         CH_DEB_PRESS: begin
            if (!s) begin
               state_d = CH_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = CH_HELD;
               press   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CH_HELD: begin
            if (!s) begin
               state_d = CH_DEB_RELEASE;
               cnt_d   = '0;
            end
         end
         CH_DEB_RELEASE: begin
            if (s) begin
               state_d = CH_HELD;
            end else if (cnt_q == CNT_LAST) begin
               state_d = CH_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = CH_LOCKED;
      endcase
   end

endmodule

// File: rtl/player_input_array.sv
// Multi-player button front end: per-player debounced channels feeding the
// lobby ready flags, race positions and first-to-finish winner arbitration.
module player_input_array
   import racer_pkg::*;
#(
   parameter  int NUM_PLAYERS     = 4,
   parameter  int MAX_POS         = 16,
   parameter  int DEBOUNCE_CYCLES = 4,
   localparam int PW              = $clog2(MAX_POS),
   localparam int IW              = clog2_min1(NUM_PLAYERS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_PLAYERS-1:0]    btn,
   input  logic [1:0]                current_screen,
   output logic [NUM_PLAYERS*PW-1:0] cur_pos,
   output logic [NUM_PLAYERS-1:0]    activity,
   output logic [NUM_PLAYERS-1:0]    ready_to_play,
   output logic                      all_ready,
   output logic                      winner_valid,
   output logic [IW-1:0]             winner_id
);

   localparam logic [PW-1:0] POS_LAST = PW'(MAX_POS - 1);

   logic [NUM_PLAYERS-1:0]         press;
   logic [NUM_PLAYERS-1:0][PW-1:0] pos_q, pos_d;
   logic [NUM_PLAYERS-1:0]         ready_q, ready_d;
   logic [NUM_PLAYERS-1:0]         arrive;
   logic                           win_vld_q, win_hit;
   logic [IW-1:0]                  win_id_q, win_idx;
   logic                           all_ready_q;
   logic [1:0]                     prev_screen;
   logic                           game_clear;

   generate
      for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_ch
         player_btn_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .btn      (btn[i]),
            .press    (press[i]),
            .activity (activity[i])
         );
      end
   endgenerate

   // Returning to the lobby from any other screen starts a fresh game.
   assign game_clear = (current_screen == SCREEN_LOBBY) && (prev_screen != SCREEN_LOBBY);

   always_comb begin
      pos_d   = pos_q;
      ready_d = ready_q;
      arrive  = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (press[i]) begin
            if (current_screen == SCREEN_LOBBY) begin
               ready_d[i] = 1'b1;
            end else if (current_screen == SCREEN_RACE && ready_q[i] && !win_vld_q &&
                         pos_q[i] < POS_LAST) begin
               pos_d[i]  = pos_q[i] + 1'b1;
               arrive[i] = (pos_d[i] == POS_LAST);
            end
         end
      end
   end

   // Lowest-index arrival wins a tie; scan downward so the last hit kept is lowest.
   always_comb begin
      win_hit = 1'b0;
      win_idx = '0;
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         if (arrive[i]) begin
            win_hit = 1'b1;
            win_idx = IW'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos_q       <= '0;
         ready_q     <= '0;
         win_vld_q   <= 1'b0;
         win_id_q    <= '0;
         all_ready_q <= 1'b0;
         prev_screen <= SCREEN_LOBBY;
      end else begin
         prev_screen <= current_screen;
         if (game_clear) begin
            pos_q       <= '0;
            ready_q     <= '0;
            win_vld_q   <= 1'b0;
            win_id_q    <= '0;
            all_ready_q <= 1'b0;
         end else begin
            pos_q       <= pos_d;
            ready_q     <= ready_d;
            all_ready_q <= &ready_q;
            if (!win_vld_q && win_hit) begin
               win_vld_q <= 1'b1;
               win_id_q  <= win_idx;
            end
         end
      end
   end

   assign cur_pos       = pos_q;
   assign ready_to_play = ready_q;
   assign all_ready     = all_ready_q;
   assign winner_valid  = win_vld_q;
   assign winner_id     = win_id_q;

endmodule

// File: doc/player_input_array.md
# player_input_array

Multi-player generalisation of the single-button player input. It handles `NUM_PLAYERS` buttons and gives each one a 2-flop synchroniser, a debounce counter and a press/release FSM. It keeps a per-player ready flag and race position, and arbitrates the first player to reach the finish. It sits between the board buttons and the screen controller / LED renderer, which consume `cur_pos`, `ready_to_play`, `all_ready` and the winner outputs.

## Interface
- `NUM_PLAYERS`, 4: number of button channels, ≥1.
- `MAX_POS`, 16: track length; positions run 0..MAX_POS-1, ≥2.
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples required to accept a press or release, ≥1.
- Derived `PW = $clog2(MAX_POS)`, `IW = max(1, $clog2(NUM_PLAYERS))`.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `btn`  in  NUM_PLAYERS  raw button levels, asynchronous to `clk`.
- `current_screen`  in  2  00 lobby, 01 race, 10 finish, 11 reserved.
- `cur_pos`  out  NUM_PLAYERS*PW  player i occupies bits [i*PW +: PW].
- `activity`  out  NUM_PLAYERS  synchronised, undebounced button level.
- `ready_to_play`  out  NUM_PLAYERS  player has joined in the lobby.
- `all_ready`  out  1  every `ready_to_play` bit set.
- `winner_valid`  out  1  sticky; a player reached MAX_POS-1.
- `winner_id`  out  IW  index of winner; valid while `winner_valid`.

## Operation
- Reset values: all outputs 0, all channel FSMs LOCKED, debounce counters 0, synchronisers 0, `prev_screen` = 00.
- Channel FSM, per player, on synchronised level `s`:
  - LOCKED: enters IDLE when `s`=0. A button held through reset is never counted.
  - IDLE: `s`=1 goes to DEB_PRESS with counter cleared.
  - DEB_PRESS: while `s`=1 the counter increments. When it reaches DEBOUNCE_CYCLES-1 with `s`=1, the FSM enters HELD and emits a one-cycle `press` pulse. `s`=0 returns to IDLE.
  - HELD: `s`=0 goes to DEB_RELEASE with counter cleared.
  - DEB_RELEASE: symmetric to DEB_PRESS. DEBOUNCE_CYCLES consecutive zeros reach IDLE; `s`=1 returns to HELD.
  - Exactly one `press` pulse per accepted press.
- Game logic on `press[i]`:
  - Screen 00: set `ready_to_play[i]`. A repeat press has no effect.
  - Screen 01: if `ready_to_play[i]` and not `winner_valid` and `cur_pos[i]` < MAX_POS-1, increment `cur_pos[i]`. Otherwise no change.
  - Screens 10 and 11: ignored.
- Winner:
  - The first cycle in which any incremented position equals MAX_POS-1 sets `winner_valid`=1 and latches `winner_id`.
  - On simultaneous arrivals, the lowest index wins; every arriving player's position still updates.
  - `winner_valid` blocks all further increments.
- Game clear: when `current_screen`=00 and `prev_screen`≠00, the block synchronously zeroes all `cur_pos`, `ready_to_play` and winner state. The channel FSMs are untouched. A press in that same cycle is ignored.
- Position arithmetic is unsigned PW-bit. It saturates at MAX_POS-1 and never wraps.

## Timing
- `btn` → `activity`: 2 cycles (synchroniser).
- `btn` rising, held stable → `press`: 2 + DEBOUNCE_CYCLES cycles.
- `press` → `cur_pos` / `ready_to_play` update: 1 cycle, registered.
- Total `btn` edge → position change: DEBOUNCE_CYCLES + 3 cycles, i.e. 7 with defaults.
- `winner_valid` / `winner_id` update on the same edge as the winning `cur_pos`.
- `all_ready` is registered, 1 cycle after the last `ready_to_play` bit sets.
- Reset asserted mid-debounce or mid-race clears everything immediately. After release, a held button requires low, then a full debounce, before counting.
- Minimum accepted press rate: 2*DEBOUNCE_CYCLES + 2 cycles per press.

## Structure
- Package `racer_pkg` holds:
  - screen encodings `SCREEN_LOBBY`/`SCREEN_RACE`/`SCREEN_FINISH`;
  - channel state constants `CH_LOCKED`, `CH_IDLE`, `CH_DEB_PRESS`, `CH_HELD`, `CH_DEB_RELEASE` (3-bit).
- Sub-module `player_btn_channel` contains the synchroniser, debounce counter and FSM, with outputs `press` and `activity`. It is instantiated NUM_PLAYERS times in a generate loop.
- The top level holds the position/ready registers, the priority winner encoder and `prev_screen`.

## Test plan
- Defaults, screen 00: hold `btn[2]` high 10 cycles. `ready_to_play`=0100 on cycle 7. Then hold all four buttons: `all_ready`=1 one cycle after the last ready bit sets.
- Bounce: on `btn[0]`, pulse 1,1,0,1,1,1,1,1 per cycle. Exactly one `press`; `cur_pos[0]` goes 0→1 in race.
- Race: 15 clean presses on player 1. `cur_pos[1]`=15, `winner_valid`=1, `winner_id`=1. A 16th press leaves 15 and no wrap.
- Tie: players 0 and 3 at 14 press in the same cycle. Both reach 15; `winner_id`=0.
- Unready player in race: presses on player 2 with `ready_to_play[2]`=0 leave `cur_pos[2]`=0.
- Reset: assert `reset` with `btn[1]` held at position 5. All outputs go 0 asynchronously. After release with `btn[1]` still high, there is no press until it is released and pressed again. Separately, screen 10→00 clears positions, ready bits and winner.
